// File: rtl/serial_bit_source_if.sv
// Parallel-word handshake and serial output bundle
// for the sequence-detector feeder.
interface serial_bit_source_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             x;
  logic             x_valid;
  logic             frame_start;
  logic             frame_last;
  logic             busy;

  modport master (
    output din,
    output din_valid,
    input  din_ready,
    input  x,
    input  x_valid,
    input  frame_start,
    input  frame_last,
    input  busy
  );

  modport slave (
    input  din,
    input  din_valid,
    output din_ready,
    output x,
    output x_valid,
    output frame_start,
    output frame_last,
    output busy
  );
endinterface

// File: rtl/serial_bit_source.sv
// Word-to-bit serializer feeding the detector FSM;
// a one-word holding register keeps frames gapless.
module serial_bit_source #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input logic            clk,
  input logic            reset,
  serial_bit_source_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t st, st_n;

  logic [WIDTH-1:0] sreg, sreg_n;
  logic [WIDTH-1:0] hold, hold_n;
  logic             hold_full, hold_full_n;
  logic [CW-1:0]    cnt, cnt_n;

  logic accept;
  logic last_bit;

  logic x_q, x_n;
  logic xv_q, xv_n;
  logic fs_q, fs_n;
  logic fl_q, fl_n;
  logic busy_q, busy_n;

  function automatic logic head(
    input logic [WIDTH-1:0] w
  );
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(
    input logic [WIDTH-1:0] w
  );
    if (MSB_FIRST)
      return {w[WIDTH-2:0], 1'b0};
    else
      return {1'b0, w[WIDTH-1:1]};
  endfunction

  assign bus.din_ready   = ~hold_full;
  assign bus.x           = x_q;
  assign bus.x_valid     = xv_q;
  assign bus.frame_start = fs_q;
  assign bus.frame_last  = fl_q;
  assign bus.busy        = busy_q;

  assign accept   = bus.din_valid & ~hold_full;
  assign last_bit = (st == SHIFT) && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      st        <= IDLE;
      sreg      <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      cnt       <= '0;
      x_q       <= IDLE_BIT;
      xv_q      <= 1'b0;
      fs_q      <= 1'b0;
      fl_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      st        <= st_n;
      sreg      <= sreg_n;
      hold      <= hold_n;
      hold_full <= hold_full_n;
      cnt       <= cnt_n;
      x_q       <= x_n;
      xv_q      <= xv_n;
      fs_q      <= fs_n;
      fl_q      <= fl_n;
      busy_q    <= busy_n;
    end
  end

  always_comb begin
    st_n        = st;
    sreg_n      = sreg;
    hold_n      = hold;
    hold_full_n = hold_full;
    cnt_n       = cnt;
    unique case (st)
      IDLE: begin
        if (accept) begin
          st_n   = SHIFT;
          sreg_n = bus.din;
          cnt_n  = '0;
        end
      end
      SHIFT: begin
        if (last_bit) begin
          // Refill from hold first; din_ready is low then.
          if (hold_full) begin
            sreg_n      = hold;
            hold_full_n = 1'b0;
            cnt_n       = '0;
          end else if (accept) begin
            sreg_n = bus.din;
            cnt_n  = '0;
          end else begin
            st_n  = IDLE;
            cnt_n = '0;
          end
        end else begin
          sreg_n = advance(sreg);
          cnt_n  = cnt + CW'(1);
          if (accept) begin
            hold_n      = bus.din;
            hold_full_n = 1'b1;
          end
        end
      end
      default: begin
        st_n = IDLE;
      end
    endcase
  end

  // Outputs are registered from next-state values.
  always_comb begin
    x_n    = IDLE_BIT;
    xv_n   = 1'b0;
    fs_n   = 1'b0;
    fl_n   = 1'b0;
    busy_n = hold_full_n;
    if (st_n == SHIFT) begin
      x_n    = head(sreg_n);
      xv_n   = 1'b1;
      fs_n   = (cnt_n == '0);
      fl_n   = (cnt_n == LAST);
      busy_n = 1'b1;
    end
  end

endmodule

// File: doc/serial_bit_source.md
Name: serial_bit_source

Overview:
- Upstream feeder for the serial sequence-detector FSM.
- Accepts parallel words through a valid/ready handshake.
- Shifts each word out one bit per clock on x, which drives the FSM's x input.
- A one-word holding register gives gapless back-to-back frames, so the detector sees continuous streams, including overlapping patterns across word boundaries.

Parameters:
- WIDTH, 8: bits per word; legal range 2..32.
- MSB_FIRST, 1: 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
- IDLE_BIT, 0: value driven on x when no frame is active.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- din  input  WIDTH  parallel word to serialize.
- din_valid  input  1  din holds a word.
- din_ready  output  1  block can accept a word this cycle.
- x  output  1  serial bit to the detector FSM.
- x_valid  output  1  x carries a frame bit.
- frame_start  output  1  high during the first bit of each word.
- frame_last  output  1  high during the last bit of each word.
- busy  output  1  shifter active or holding register full.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, sampled on the clk rising edge.
- Reset values (all outputs registered):
  - x=IDLE_BIT; x_valid=0; frame_start=0; frame_last=0; busy=0; din_ready=1.
  - Shifter, holding register, hold_full flag and bit counter are cleared. State=IDLE.
- State machine: IDLE and SHIFT.
- Accept rule: a word is taken at a rising edge where din_valid=1 and din_ready=1. din_ready = !hold_full, driven combinationally from the registered flag.
- IDLE + accept at edge E:
  - Word loads directly into the shifter (bypass); the holding register is unused.
  - State goes to SHIFT and the counter is set to 0.
  - The first bit appears on x after E, so latency is 1 cycle from accept to first bit.
- SHIFT:
  - Each edge advances the shifter one bit and increments the counter.
  - x = current head bit (MSB or LSB per MSB_FIRST); x_valid=1.
  - frame_start=1 when counter=0; frame_last=1 when counter=WIDTH-1.
- SHIFT + accept while the last bit is not on x: word goes to the holding register; hold_full=1; din_ready drops on the next cycle.
- Edge ending the last bit (counter=WIDTH-1):
  - If hold_full: the holding word moves to the shifter, hold_full clears, counter returns to 0, state stays SHIFT. There is no idle gap.
  - Else if an accept occurs at this edge: the word bypasses into the shifter, state stays SHIFT, no gap.
  - Else: state goes to IDLE. On the next cycle x=IDLE_BIT, x_valid=0, frame flags=0.
- Data stability:
  - din is sampled only at the accept edge.
  - Changes on din while din_ready=0 are ignored.
  - din_valid may drop without a transfer; no word is accepted.
- busy = (state==SHIFT) | hold_full.
- Reset mid-frame or with hold_full: both words are discarded. The next cycle shows reset values and no partial frame completes.
- Reset and accept at the same edge: reset wins and the word is dropped.
- Counter width is $clog2(WIDTH). Wrap to 0 happens only via the last-bit rule; the counter never free-runs in IDLE.

Test Plan:
- Single word, MSB_FIRST=1, WIDTH=8, din=8'hA5 accepted at edge 1 -> x over cycles 2..9 = 1,0,1,0,0,1,0,1.
  - x_valid high for exactly 8 cycles.
  - frame_start only in cycle 2; frame_last only in cycle 9.
  - Cycle 10: x=0, x_valid=0, busy=0.
- Back-to-back: din_valid held high with 8'hA5 then 8'h3C -> 16 consecutive valid bits, 1010010100111100, with no gap.
  - din_ready low from the cycle after the second accept until the first word's last-bit edge.
  - frame_start pulses at bit 0 and bit 8.
- LSB-first: MSB_FIRST=0, WIDTH=10, din=10'b1010111010 -> x = 0,1,0,1,1,1,0,1,0,1. This is the detector's reference stimulus.
  - Concatenated FSM output y matches the standalone FSM bench.
- Backpressure: shifter active and holding register full, din_valid=1 with a new value each cycle -> no accept until din_ready=1.
  - The accepted word equals din at that edge; earlier values are never sent.
- Reset mid-frame: reset asserted at bit 3 of 8'hFF with the holding register full -> next cycle x=IDLE_BIT, x_valid=0, din_ready=1, busy=0.
  - A new word sent after reset transmits cleanly from bit 0.
- Gap path: single word with din_valid dropped before the last bit -> IDLE for ≥1 cycle with x=IDLE_BIT.
  - A later accept restarts with latency 1 and frame_start=1.
